// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for the FPGA-side bus segment.
//   HTRANS / HBURST / HSIZE codes, the burst-master state encoding and a
//   helper mapping a beats-minus-one length onto the matching HBURST code.
package ahb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_LAST  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  // Fixed-length burst codes where they exist, undefined-length INCR otherwise.
  function automatic logic [2:0] burst_code(input int unsigned len_m1);
    case (len_m1)
      0:       return HBURST_SINGLE;
      3:       return HBURST_INCR4;
      7:       return HBURST_INCR8;
      15:      return HBURST_INCR16;
      default: return HBURST_INCR;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_master.sv
// ahb_burst_master: AHB-Lite initiator turning one command into a SINGLE or
// incrementing word burst. Sole master on its segment (no arbitration).
// Ports:
//   AHB_HCLK, AHB_HRESET          clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/len command handshake (len = beats - 1)
//   wr_data, wr_pop               first-word-fall-through write source
//   rd_data, rd_valid             registered read data, one pulse per beat
//   done, err                     end-of-command pulse, error flag with done
//   AHB_H*                        AHB-Lite master signals
module ahb_burst_master
  import ahb_pkg::*;
#(
  parameter int unsigned  MAX_BEATS = 16,
  parameter logic [3:0]   HPROT_VAL = 4'b0011,
  localparam int unsigned LEN_W     = $clog2(MAX_BEATS)
) (
  input  logic              AHB_HCLK,
  input  logic              AHB_HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] AHB_HADDR,
  output logic [1:0]        AHB_HTRANS,
  output logic [2:0]        AHB_HBURST,
  output logic [2:0]        AHB_HSIZE,
  output logic [3:0]        AHB_HPROT,
  output logic              AHB_HWRITE,
  output logic              AHB_HMASTLOCK,
  output logic [DATA_W-1:0] AHB_HWDATA,
  input  logic [DATA_W-1:0] AHB_HRDATA,
  input  logic              AHB_HREADY,
  input  logic              AHB_HRESP
);

  state_t              r_state,    w_state_nxt;
  logic [ADDR_W-1:0]   r_haddr,    w_haddr_nxt;
  logic [1:0]          r_htrans,   w_htrans_nxt;
  logic [2:0]          r_hburst,   w_hburst_nxt;
  logic                r_hwrite,   w_hwrite_nxt;
  logic [DATA_W-1:0]   r_hwdata,   w_hwdata_nxt;
  logic [DATA_W-1:0]   r_rd_data,  w_rd_data_nxt;
  logic                r_rd_valid, w_rd_valid_nxt;
  logic                r_done,     w_done_nxt;
  logic                r_err,      w_err_nxt;
  logic [LEN_W-1:0]    r_len,      w_len_nxt;
  logic [LEN_W-1:0]    r_acnt,     w_acnt_nxt;   // beat in address phase
  logic [LEN_W-1:0]    r_dcnt,     w_dcnt_nxt;   // beat in data phase
  logic                r_dvalid,   w_dvalid_nxt; // a data phase is outstanding
  logic                w_addr_acc;

  // Address phase accepted this cycle; HTRANS is only active in BURST.
  assign w_addr_acc = r_htrans[1] & AHB_HREADY;
  // Pop in the same cycle the FWFT head is captured into HWDATA.
  assign wr_pop     = r_hwrite & w_addr_acc;
  assign cmd_ready  = (r_state == ST_IDLE);

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt    = r_state;
    w_haddr_nxt    = r_haddr;
    w_htrans_nxt   = r_htrans;
    w_hburst_nxt   = r_hburst;
    w_hwrite_nxt   = r_hwrite;
    w_hwdata_nxt   = r_hwdata;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = 1'b0;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_len_nxt      = r_len;
    w_acnt_nxt     = r_acnt;
    w_dcnt_nxt     = r_dcnt;
    w_dvalid_nxt   = r_dvalid;

    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt  = ST_BURST;
          w_haddr_nxt  = cmd_addr & ~ADDR_W'(3);
          w_htrans_nxt = HTRANS_NONSEQ;
          w_hburst_nxt = burst_code(32'(cmd_len));
          w_hwrite_nxt = cmd_write;
          w_len_nxt    = cmd_len;
          w_acnt_nxt   = '0;
          w_dcnt_nxt   = '0;
          w_dvalid_nxt = 1'b0;
        end
      end

      ST_BURST, ST_LAST: begin
        if (r_dvalid && !AHB_HREADY && AHB_HRESP) begin
          // First ERROR cycle: cancel the remaining beats.
          w_htrans_nxt = HTRANS_IDLE;
          w_state_nxt  = ST_ERR;
        end else if (AHB_HREADY) begin
          if (r_dvalid && !r_hwrite && !AHB_HRESP) begin
            w_rd_data_nxt  = AHB_HRDATA;
            w_rd_valid_nxt = 1'b1;
          end
          if (w_addr_acc) begin
            w_dvalid_nxt = 1'b1;
            w_dcnt_nxt   = r_acnt;
            if (r_hwrite) begin
              w_hwdata_nxt = wr_data;
            end
            if (r_acnt == r_len) begin
              w_htrans_nxt = HTRANS_IDLE;
              w_state_nxt  = ST_LAST;
            end else begin
              w_haddr_nxt  = r_haddr + ADDR_W'(4);
              w_htrans_nxt = HTRANS_SEQ;
              w_acnt_nxt   = LEN_W'(r_acnt + 1'b1);
            end
          end else begin
            w_dvalid_nxt = 1'b0;
            if (r_dvalid && (r_dcnt == r_len)) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end

      ST_ERR: begin
        // Second ERROR cycle completes the errored beat.
        if (AHB_HREADY) begin
          w_state_nxt  = ST_IDLE;
          w_dvalid_nxt = 1'b0;
          w_done_nxt   = 1'b1;
          w_err_nxt    = 1'b1;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge AHB_HCLK) begin
    if (AHB_HRESET) begin
      r_state    <= ST_IDLE;
      r_haddr    <= '0;
      r_htrans   <= HTRANS_IDLE;
      r_hburst   <= HBURST_SINGLE;
      r_hwrite   <= 1'b0;
      r_hwdata   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_len      <= '0;
      r_acnt     <= '0;
      r_dcnt     <= '0;
      r_dvalid   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_haddr    <= w_haddr_nxt;
      r_htrans   <= w_htrans_nxt;
      r_hburst   <= w_hburst_nxt;
      r_hwrite   <= w_hwrite_nxt;
      r_hwdata   <= w_hwdata_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_len      <= w_len_nxt;
      r_acnt     <= w_acnt_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_dvalid   <= w_dvalid_nxt;
    end
  end

  assign AHB_HADDR     = r_haddr;
  assign AHB_HTRANS    = r_htrans;
  assign AHB_HBURST    = r_hburst;
  assign AHB_HSIZE     = HSIZE_WORD;
  assign AHB_HPROT     = HPROT_VAL;
  assign AHB_HWRITE    = r_hwrite;
  assign AHB_HMASTLOCK = 1'b0;
  assign AHB_HWDATA    = r_hwdata;
  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign done          = r_done;
  assign err           = r_err;

endmodule
